// File: rtl/alu_issue_pkg.sv
// Shared definitions for the SISD issue stage: ALU function codes, instruction
// field positions, FSM state encoding and register-file geometry.
package sisd_pkg;

   localparam int DATA_W    = 8;
   localparam int REG_IDX_W = 2;
   localparam int NUM_REGS  = 4;
   localparam int FUNC_W    = 3;
   localparam int INSTR_W   = 16;
   localparam int FLAGS_W   = 3;
   localparam int WCNT_W    = 3;

   // Instruction layout: [15:13] func, [12] imm, [11:10] rd, [9:8] rs1,
   // [7:0] imm8 when imm=1, otherwise [1:0] rs2.
   localparam int FUNC_MSB = 15;
   localparam int FUNC_LSB = 13;
   localparam int IMM_BIT  = 12;
   localparam int RD_MSB   = 11;
   localparam int RD_LSB   = 10;
   localparam int RS1_MSB  = 9;
   localparam int RS1_LSB  = 8;
   localparam int IMM8_MSB = 7;
   localparam int RS2_MSB  = 1;

   typedef enum logic [FUNC_W-1:0] {
      FUNC_ADD = 3'b000,
      FUNC_SUB = 3'b001,
      FUNC_AND = 3'b010,
      FUNC_OR  = 3'b011,
      FUNC_SHL = 3'b100,
      FUNC_SHR = 3'b101,
      FUNC_XOR = 3'b110,
      FUNC_NOP = 3'b111
   } alu_func_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   function automatic logic func_writes(input alu_func_t func);
      return func != FUNC_NOP;
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the instruction handshake, ALU drive/return and writeback signals.
// slave = the issue stage, master = whatever feeds it and hosts the ALU.
interface alu_issue_if;
   import sisd_pkg::*;

   logic [INSTR_W-1:0] i_instr;
   logic               i_valid;
   logic               o_ready;
   logic [DATA_W-1:0]  o_alu_s1;
   logic [DATA_W-1:0]  o_alu_s2;
   logic [FUNC_W-1:0]  o_alu_func;
   logic               o_alu_en;
   logic [DATA_W-1:0]  i_alu_result;
   logic               i_alu_zero;
   logic               i_alu_negative;
   logic               i_alu_overflow;
   logic               o_wb_valid;
   logic [REG_IDX_W-1:0] o_wb_rd;
   logic [DATA_W-1:0]  o_wb_data;
   logic [FLAGS_W-1:0] o_flags;

   modport slave (
      input  i_instr, i_valid, i_alu_result, i_alu_zero, i_alu_negative, i_alu_overflow,
      output o_ready, o_alu_s1, o_alu_s2, o_alu_func, o_alu_en,
             o_wb_valid, o_wb_rd, o_wb_data, o_flags
   );

   modport master (
      output i_instr, i_valid, i_alu_result, i_alu_zero, i_alu_negative, i_alu_overflow,
      input  o_ready, o_alu_s1, o_alu_s2, o_alu_func, o_alu_en,
             o_wb_valid, o_wb_rd, o_wb_data, o_flags
   );

endinterface

// File: rtl/alu_issue_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port,
// synchronous active-low clear of every register.
module sisd_regfile
   import sisd_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [REG_IDX_W-1:0] i_raddr_a,
   input  logic [REG_IDX_W-1:0] i_raddr_b,
   output logic [DATA_W-1:0]    o_rdata_a,
   output logic [DATA_W-1:0]    o_rdata_b,
   input  logic                 i_we,
   input  logic [REG_IDX_W-1:0] i_waddr,
   input  logic [DATA_W-1:0]    i_wdata
);

   logic [DATA_W-1:0] r_mem [NUM_REGS];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue.sv
// Single-issue stage in front of the SISD ALU: accept, hold operands for
// WAIT_CYCLES+1 cycles, write back. Status register exists only with ALU_ISSUE_FLAGS_EN.
module alu_issue
   import sisd_pkg::*;
#(
   parameter int WAIT_CYCLES = 0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   alu_issue_if.slave bus
);

   localparam logic [WCNT_W-1:0] LP_WAIT = WCNT_W'(WAIT_CYCLES);

   state_t               r_state;
   alu_func_t            r_func;
   logic [REG_IDX_W-1:0] r_rd;
   logic [DATA_W-1:0]    r_s1;
   logic [DATA_W-1:0]    r_s2;
   logic [WCNT_W-1:0]    r_cnt;
   logic                 r_ready;
   logic                 r_alu_en;
   logic                 r_wb_valid;
   logic [REG_IDX_W-1:0] r_wb_rd;
   logic [DATA_W-1:0]    r_wb_data;

   logic [REG_IDX_W-1:0] w_rs1;
   logic [REG_IDX_W-1:0] w_rs2;
   logic [REG_IDX_W-1:0] w_rd;
   logic                 w_imm;
   logic [DATA_W-1:0]    w_imm8;
   logic [DATA_W-1:0]    w_rdata1;
   logic [DATA_W-1:0]    w_rdata2;
   logic                 w_final;
   logic                 w_writes;
   logic                 w_we;

   assign w_rs1    = bus.i_instr[RS1_MSB:RS1_LSB];
   assign w_rs2    = bus.i_instr[RS2_MSB:0];
   assign w_rd     = bus.i_instr[RD_MSB:RD_LSB];
   assign w_imm    = bus.i_instr[IMM_BIT];
   assign w_imm8   = bus.i_instr[IMM8_MSB:0];
   assign w_final  = (r_state == ST_EXEC) && (r_cnt == '0);
   assign w_writes = func_writes(r_func);
   assign w_we     = w_final && w_writes;

   sisd_regfile u_regfile (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_raddr_a (w_rs1),
      .i_raddr_b (w_rs2),
      .o_rdata_a (w_rdata1),
      .o_rdata_b (w_rdata2),
      .i_we      (w_we),
      .i_waddr   (r_rd),
      .i_wdata   (bus.i_alu_result)
   );

   // r_ready is high exactly in IDLE, so accepting never depends on i_valid combinationally.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_ready    <= 1'b1;
         r_alu_en   <= 1'b0;
         r_wb_valid <= 1'b0;
         r_func     <= FUNC_ADD;
         r_rd       <= '0;
         r_s1       <= '0;
         r_s2       <= '0;
         r_cnt      <= '0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (bus.i_valid) begin
                  r_func   <= alu_func_t'(bus.i_instr[FUNC_MSB:FUNC_LSB]);
                  r_rd     <= w_rd;
                  r_s1     <= w_rdata1;
                  r_s2     <= w_imm ? w_imm8 : w_rdata2;
                  r_cnt    <= LP_WAIT;
                  r_ready  <= 1'b0;
                  r_alu_en <= 1'b1;
                  r_state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_alu_en   <= 1'b0;
                  r_wb_valid <= w_writes;
                  if (w_writes) begin
                     r_wb_rd   <= r_rd;
                     r_wb_data <= bus.i_alu_result;
                  end
                  r_state <= ST_WB;
               end
            end
            ST_WB: begin
               r_wb_valid <= 1'b0;
               r_ready    <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_wb_valid <= 1'b0;
               r_alu_en   <= 1'b0;
               r_ready    <= 1'b1;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_ready    = r_ready;
   assign bus.o_alu_en   = r_alu_en;
   assign bus.o_alu_s1   = r_s1;
   assign bus.o_alu_s2   = r_s2;
   assign bus.o_alu_func = r_func;
   assign bus.o_wb_valid = r_wb_valid;
   assign bus.o_wb_rd    = r_wb_rd;
   assign bus.o_wb_data  = r_wb_data;

`ifdef ALU_ISSUE_FLAGS_EN
   logic [FLAGS_W-1:0] r_flags;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_flags <= '0;
      end else if (w_we) begin
         r_flags <= {bus.i_alu_overflow, bus.i_alu_negative, bus.i_alu_zero};
      end
   end

   assign bus.o_flags = r_flags;
`else
   logic w_unused_flags;
   assign w_unused_flags = ^{bus.i_alu_overflow, bus.i_alu_negative, bus.i_alu_zero};
   assign bus.o_flags    = '0;
`endif

endmodule
